piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in, parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock on a serial output, with a matching valid qualifier.
- Intended to drive the SIPO's serial input directly, with `out_valid` gating the receiver's shifting.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset.
- load_valid  input  1  D holds a word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- D  input  WIDTH  parallel data word.
- shift_en  input  1  consume the current serial bit this cycle (stall when 0).
- Out  output  1  serial data bit.
- out_valid  output  1  Out carries a valid data bit.
- busy  output  1  a word is in progress (state SHIFT).
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, shift register=0, bit counter=0, done=0.
  - Resulting outputs: load_ready=1, out_valid=0, busy=0, Out=0.
  - Reset asserted mid-word aborts the word immediately; no done pulse is produced.
- Internal state:
  - FSM states: IDLE, SHIFT.
  - Shift register `sreg`, WIDTH bits.
  - Counter `cnt`, clog2(WIDTH) bits, counting 0..WIDTH-1.
- Load accept: rising edge with load_valid=1 and load_ready=1 → sreg<=D, cnt<=0, state<=SHIFT.
- load_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT only when shift_en=1 and cnt=WIDTH-1 (last bit being consumed).
  - 0 otherwise.
- load_valid while load_ready=0 is ignored; D is not sampled and the current word is unaffected.
- Out (combinational):
  - In SHIFT: Out = sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0].
  - In IDLE: Out=0.
- out_valid = busy = (state==SHIFT).
- In SHIFT, an edge with shift_en=1:
  - Bit consumed; sreg shifts toward the output end, zero-filled (left if MSB_FIRST=1, right otherwise).
  - cnt<=cnt+1.
- In SHIFT, an edge with shift_en=0: sreg, cnt, Out and state hold.
- Last bit (shift_en=1 and cnt=WIDTH-1):
  - done<=1 for exactly the next cycle.
  - If a load is accepted on the same edge: new word loaded, state stays SHIFT, no idle gap. Back-to-back throughput is one bit per cycle.
  - Otherwise: state<=IDLE.
- done is registered and is 0 in all other cycles.
- Latency: the first bit is on Out in the cycle immediately after the load edge.
  - With shift_en held at 1, the word occupies exactly WIDTH cycles.
  - done is high in cycle WIDTH+1 after the load.
- No X propagation: Out is 0 whenever out_valid=0.

Test Plan:
1. Reset, then WIDTH=4, MSB_FIRST=1; load D=4'b1011 with shift_en=1 held → Out=1,0,1,1 over 4 cycles with out_valid=1; done=1 in the 5th cycle; then load_ready=1, busy=0, Out=0.
2. MSB_FIRST=0, D=4'b1011 → Out=1,1,0,1; done after 4 bits.
3. Stall: load 4'b1100; drop shift_en for 3 cycles after the first bit → Out holds 1 for 4 cycles, then continues 1,0,0; done only after the 4th consumed bit.
4. Back-to-back: load 4'b1010, then present 4'b0111 with load_valid=1 during the last bit → continuous stream 1,0,1,0,0,1,1,1; out_valid never drops; done pulses in cycle 5 (data continues) and again after the 8th bit.
5. Load while busy: assert load_valid with D=4'b1111 during bit 2 of 4'b0001 → ignored (load_ready=0); stream remains 0,0,0,1.
6. Reset mid-word: assert clr=0 asynchronously (not clock-aligned) during bit 2 of 4'b1001 → out_valid, busy, Out go 0 immediately; done never pulses; load_ready=1 after clr releases; a new load then works normally.

Source files
------------

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Emits one bit per enabled clock and supports back-to-back words with no idle gap.
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D,
    input  logic             shift_en,
    output logic             Out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             accept;

    // Last bit is being consumed this cycle; frees the register for a new word.
    assign last_bit   = (state == SHIFT) && shift_en && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    assign busy      = (state == SHIFT);
    assign out_valid = (state == SHIFT);

    always_comb begin
        Out = 1'b0;
        if (state == SHIFT) begin
            Out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational logic above uses continuous assigns.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_bit;
            if (accept) begin
                sreg  <= D;
                cnt   <= '0;
                state <= SHIFT;
            end else if ((state == SHIFT) && shift_en) begin
                sreg  <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a bit-queue model, plus directed literal checks.
module tb_piso_shift_register;

    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic         load_valid;
    logic [W-1:0] D;
    logic         shift_en;

    logic m_ready, m_out, m_valid, m_busy, m_done;
    logic l_ready, l_out, l_valid, l_busy, l_done;

    int checks = 0;
    int errors = 0;

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(m_ready),
        .D(D), .shift_en(shift_en), .Out(m_out), .out_valid(m_valid),
        .busy(m_busy), .done(m_done)
    );

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(l_ready),
        .D(D), .shift_en(shift_en), .Out(l_out), .out_valid(l_valid),
        .busy(l_busy), .done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes WIDTH queued bits in transmit order.
    bit q_m[$];
    bit q_l[$];
    bit exp_done;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_m.delete();
            q_l.delete();
            exp_done = 1'b0;
        end else begin
            automatic bit rdy  = (q_m.size() == 0) || (shift_en && q_m.size() == 1);
            automatic bit last = shift_en && (q_m.size() == 1);
            if (shift_en && q_m.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (load_valid && rdy) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(D[i]);
                for (int i = 0; i < W; i++) q_l.push_back(D[i]);
            end
            exp_done = last;
        end
    end

    always @(negedge clk) begin
        automatic bit act  = q_m.size() > 0;
        automatic bit rdy  = (q_m.size() == 0) || (shift_en && q_m.size() == 1);
        automatic bit em   = act ? q_m[0] : 1'b0;
        automatic bit el   = act ? q_l[0] : 1'b0;
        check("m_out",   m_out,   em);
        check("m_valid", m_valid, act);
        check("m_busy",  m_busy,  act);
        check("m_ready", m_ready, rdy);
        check("m_done",  m_done,  exp_done);
        check("l_out",   l_out,   el);
        check("l_valid", l_valid, act);
        check("l_ready", l_ready, rdy);
        check("l_done",  l_done,  exp_done);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_m;
        logic [3:0] exp_l;
        logic [7:0] exp8;
        logic [6:0] exp7;
        logic [6:0] en7;

        clr = 1'b0; load_valid = 1'b0; D = '0; shift_en = 1'b0;
        #12;
        check("rst_ready", m_ready, 1);
        check("rst_valid", m_valid, 0);
        check("rst_out",   m_out,   0);
        check("rst_done",  m_done,  0);
        clr = 1'b1;
        step();

        // Plan 1 and 2: D=1011, MSB gives 1,0,1,1; LSB gives 1,1,0,1.
        exp_m = 4'b1011; exp_l = 4'b1011;
        load_valid = 1'b1; D = 4'b1011; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_out_m", m_out, exp_m[3-i]);
            check("t2_out_l", l_out, exp_l[i]);
            check("t1_valid", m_valid, 1);
            check("t1_ndone", m_done, 0);
            step();
        end
        check("t1_done",  m_done,  1);
        check("t2_done",  l_done,  1);
        check("t1_busy",  m_busy,  0);
        check("t1_ready", m_ready, 1);
        check("t1_out0",  m_out,   0);
        step();
        check("t1_done_once", m_done, 0);

        // Plan 3: stall on the first bit of 1100.
        exp7 = 7'b1111100; en7 = 7'b0001111;
        load_valid = 1'b1; D = 4'b1100; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            shift_en = en7[6-i];
            check("t3_out", m_out, exp7[6-i]);
            check("t3_ndone", m_done, 0);
            step();
        end
        check("t3_done", m_done, 1);
        step();

        // Plan 4: back-to-back 1010 then 0111.
        exp8 = 8'b10100111;
        load_valid = 1'b1; D = 4'b1010; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1; D = 4'b0111;
                check("t4_ready_last", m_ready, 1);
            end else begin
                load_valid = 1'b0;
            end
            check("t4_out", m_out, exp8[7-i]);
            check("t4_valid", m_valid, 1);
            check("t4_done", m_done, (i == 4) ? 1 : 0);
            step();
        end
        load_valid = 1'b0;
        check("t4_done2", m_done, 1);
        check("t4_busy", m_busy, 0);
        step();

        // Plan 5: load attempt while busy is ignored.
        exp_m = 4'b0001;
        load_valid = 1'b1; D = 4'b0001;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                load_valid = 1'b1; D = 4'b1111;
                check("t5_ready", m_ready, 0);
            end else begin
                load_valid = 1'b0;
            end
            check("t5_out", m_out, exp_m[3-i]);
            step();
        end
        load_valid = 1'b0;
        check("t5_done", m_done, 1);
        step();

        // Plan 6: asynchronous reset during bit 2 of 1001.
        load_valid = 1'b1; D = 4'b1001;
        step();
        load_valid = 1'b0;
        step();
        check("t6_bit2", m_out, 0);
        check("t6_busy_pre", m_busy, 1);
        #2 clr = 1'b0;
        #1;
        check("t6_valid", m_valid, 0);
        check("t6_busy",  m_busy,  0);
        check("t6_out",   l_out,   0);
        check("t6_ready", m_ready, 1);
        step();
        check("t6_ndone", m_done, 0);
        #3 clr = 1'b1;
        step();
        check("t6_ndone2", m_done, 0);
        check("t6_ready2", m_ready, 1);
        exp_m = 4'b0110;
        load_valid = 1'b1; D = 4'b0110;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_out_new", m_out, exp_m[3-i]);
            step();
        end
        check("t6_done_new", m_done, 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
